// File: rtl/pad_cfg_pkg.sv
// pad_cfg_pkg: shared types and constants for the pad-configuration APB sequencer.
//   - pad_cfg_state_e : sequencer FSM states (read-back states exist only when
//                       PAD_CFG_VERIFY_EN is defined)
//   - register offsets of the pad-control slave and pad address stride
//   - pack_pad_cfg()  : spreads a 6-bit pad config into the slave's 32-bit word
package pad_cfg_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StAccess = 3'd2,
        StDone   = 3'd3
`ifdef PAD_CFG_VERIFY_EN
        ,
        StRSetup  = 3'd4,
        StRAccess = 3'd5
`endif
    } pad_cfg_state_e;

    localparam logic [31:0] REG_PAD_MUX_OFS  = 32'h0000_0000;
    localparam logic [31:0] REG_PAD_CONF_OFS = 32'h0000_0004;

    // Pad k's config register sits at (k << PAD_IDX_SHIFT) + REG_PAD_CONF_OFS.
    localparam int unsigned PAD_IDX_SHIFT = 5;
    localparam int unsigned PAD_CFG_W     = 6;

    // Config field b lands on bit 5*b of the slave's data word.
    localparam int unsigned PAD_FLD0_POS = 0;
    localparam int unsigned PAD_FLD1_POS = 5;
    localparam int unsigned PAD_FLD2_POS = 10;
    localparam int unsigned PAD_FLD3_POS = 15;
    localparam int unsigned PAD_FLD4_POS = 20;
    localparam int unsigned PAD_FLD5_POS = 25;

    function automatic logic [31:0] pack_pad_cfg(input logic [PAD_CFG_W-1:0] cfg);
        logic [31:0] w_word;
        w_word               = '0;
        w_word[PAD_FLD0_POS] = cfg[0];
        w_word[PAD_FLD1_POS] = cfg[1];
        w_word[PAD_FLD2_POS] = cfg[2];
        w_word[PAD_FLD3_POS] = cfg[3];
        w_word[PAD_FLD4_POS] = cfg[4];
        w_word[PAD_FLD5_POS] = cfg[5];
        return w_word;
    endfunction

endpackage

// File: rtl/apb_pad_cfg_sequencer.sv
// apb_pad_cfg_sequencer: APB master that programs the pad-control slave on request.
// On start_i (in IDLE) it snapshots mux_val_i / cfg_val_i and issues back-to-back
// APB writes: the pad-mux word, then one config word per pad.
// Optional macro PAD_CFG_VERIFY_EN: every write is followed by a read-back of the
// same address; a data mismatch or PSLVERR aborts the sequence with error_o set.
// Ports:
//   HCLK, HRESET            clock, synchronous active-high reset
//   start_i                 request a sequence (only honoured in IDLE)
//   mux_val_i, cfg_val_i    pad-mux word, packed 6-bit per-pad configs
//   busy_o, done_o, error_o status: in progress, end pulse, sticky error
//   PADDR..PENABLE          APB master request outputs
//   PRDATA, PREADY, PSLVERR APB slave response inputs
module apb_pad_cfg_sequencer
    import pad_cfg_pkg::*;
#(
    parameter int unsigned                APB_ADDR_WIDTH = 12,
    parameter int unsigned                N_PADS         = 21,
    parameter logic [APB_ADDR_WIDTH-1:0]  BASE_ADDR      = '0
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic                        start_i,
    input  logic [31:0]                 mux_val_i,
    input  logic [6*N_PADS-1:0]         cfg_val_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [APB_ADDR_WIDTH-1:0]   PADDR,
    output logic [31:0]                 PWDATA,
    output logic                        PWRITE,
    output logic                        PSEL,
    output logic                        PENABLE,
    input  logic [31:0]                 PRDATA,
    input  logic                        PREADY,
    input  logic                        PSLVERR
);

    localparam int unsigned CFG_W    = PAD_CFG_W * N_PADS;
    localparam logic [5:0]  LAST_IDX = 6'(N_PADS);

    pad_cfg_state_e r_state, w_state_next;

    // r_idx is the entry currently on the bus: 0 = mux word, j = pad j-1.
    logic [5:0]                r_idx;
    logic [CFG_W-1:0]          r_cfg;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    // Holds the mux snapshot for entry 0, then each pad's packed word.
    logic [31:0]               r_pwdata;
    logic                      r_error;

    logic                      w_last;
    logic                      w_advance;
    logic                      w_set_error;
    logic [PAD_CFG_W-1:0]      w_next_cfg;
    logic [APB_ADDR_WIDTH-1:0] w_next_addr;

    // The next entry after r_idx is pad k = r_idx.
    assign w_last      = (r_idx == LAST_IDX);
    assign w_next_cfg  = r_cfg[r_idx*PAD_CFG_W +: PAD_CFG_W];
    assign w_next_addr = BASE_ADDR
                       + APB_ADDR_WIDTH'(32'(r_idx) << PAD_IDX_SHIFT)
                       + APB_ADDR_WIDTH'(REG_PAD_CONF_OFS);

`ifndef PAD_CFG_VERIFY_EN
    logic w_unused_prdata;
    assign w_unused_prdata = ^PRDATA;
`endif

    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        w_set_error  = 1'b0;
        unique case (r_state)
            StIdle:   if (start_i) w_state_next = StSetup;
            StSetup:  w_state_next = StAccess;
            StAccess: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        w_set_error  = 1'b1;
                        w_state_next = StDone;
`ifdef PAD_CFG_VERIFY_EN
                    end else begin
                        w_state_next = StRSetup;
                    end
`else
                    end else if (w_last) begin
                        w_state_next = StDone;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = StSetup;
                    end
`endif
                end
            end
`ifdef PAD_CFG_VERIFY_EN
            StRSetup:  w_state_next = StRAccess;
            StRAccess: begin
                if (PREADY) begin
                    if (PSLVERR || (PRDATA != r_pwdata)) begin
                        w_set_error  = 1'b1;
                        w_state_next = StDone;
                    end else if (w_last) begin
                        w_state_next = StDone;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = StSetup;
                    end
                end
            end
`endif
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        done_o  = 1'b0;
        unique case (r_state)
            StSetup:   begin PSEL = 1'b1; PWRITE = 1'b1; end
            StAccess:  begin PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b1; end
`ifdef PAD_CFG_VERIFY_EN
            StRSetup:  PSEL = 1'b1;
            StRAccess: begin PSEL = 1'b1; PENABLE = 1'b1; end
`endif
            StDone:    done_o = 1'b1;
            default:   ;
        endcase
    end

    // busy_o tracks PSEL: high in every state but IDLE and DONE.
    assign busy_o  = PSEL;
    assign error_o = r_error;
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state  <= StIdle;
            r_idx    <= '0;
            r_cfg    <= '0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == StIdle) && start_i) begin
                r_cfg    <= cfg_val_i;
                r_idx    <= '0;
                r_error  <= 1'b0;
                r_paddr  <= BASE_ADDR + APB_ADDR_WIDTH'(REG_PAD_MUX_OFS);
                r_pwdata <= mux_val_i;
            end else if (w_advance) begin
                r_idx    <= r_idx + 6'd1;
                r_paddr  <= w_next_addr;
                r_pwdata <= pack_pad_cfg(w_next_cfg);
            end
            if (w_set_error) r_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_pad_cfg_sequencer.sv
// Testbench for apb_pad_cfg_sequencer: directed sequences against a small APB
// slave model with injectable wait states, slave errors and corrupted read data.
module tb_apb_pad_cfg_sequencer;

    localparam int unsigned AW = 12;
    localparam int unsigned NP = 21;
`ifdef PAD_CFG_VERIFY_EN
    localparam int EPC = 4;
`else
    localparam int EPC = 2;
`endif
    localparam int DONE_CYC = EPC * (NP + 1) + 1;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic              start_i;
    logic [31:0]       mux_val_i;
    logic [6*NP-1:0]   cfg_val_i;
    logic              busy_o, done_o, error_o;
    logic [AW-1:0]     PADDR;
    logic [31:0]       PWDATA;
    logic              PWRITE, PSEL, PENABLE;
    logic [31:0]       PRDATA;
    logic              PREADY, PSLVERR;

    apb_pad_cfg_sequencer #(
        .APB_ADDR_WIDTH (AW),
        .N_PADS         (NP),
        .BASE_ADDR      ('0)
    ) u_dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .start_i   (start_i),
        .mux_val_i (mux_val_i),
        .cfg_val_i (cfg_val_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .error_o   (error_o),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave model controls; -1 disables a feature.
    int          t0 = 0;
    int          stall_addr = -1;
    int          stall_left = 0;
    int          err_addr = -1;
    int          bad_rd_addr = -1;
    int          watch_addr = -1;
    bit          watch_hit = 1'b0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          done_q[$];
    logic [31:0] mem [256];

    always @(negedge HCLK) begin
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        if (PSEL && PENABLE && PWRITE && int'(PADDR) == stall_addr && stall_left > 0) begin
            PREADY = 1'b0;
            stall_left--;
        end
        if (PSEL && PENABLE && PWRITE && int'(PADDR) == err_addr) PSLVERR = 1'b1;
        PRDATA = mem[PADDR[9:2]] ^ ((int'(PADDR) == bad_rd_addr) ? 32'h1 : 32'h0);
        if (PSEL && int'(PADDR) == watch_addr) watch_hit = 1'b1;
        if (PSEL && PENABLE && PWRITE && PREADY && !PSLVERR) begin
            wr_addr_q.push_back(32'(PADDR));
            wr_data_q.push_back(PWDATA);
            mem[PADDR[9:2]] = PWDATA;
        end
        if (done_o) done_q.push_back(cyc - t0);
    end

    function automatic logic [31:0] pack_model(input logic [5:0] c);
        logic [31:0] d;
        d = '0;
        for (int b = 0; b < 6; b++) d[5*b] = c[b];
        return d;
    endfunction

    function automatic logic [6*NP-1:0] build_cfg(input logic [5:0] x);
        logic [6*NP-1:0] v;
        for (int k = 0; k < NP; k++) v[6*k +: 6] = 6'(k) ^ x;
        return v;
    endfunction

    function automatic logic [31:0] exp_addr(input int j);
        return (j == 0) ? 32'h0 : 32'((j - 1) * 32 + 4);
    endfunction

    function automatic logic [31:0] exp_data(input int j, input logic [31:0] mux,
                                             input logic [5:0] x);
        return (j == 0) ? mux : pack_model(6'(j - 1) ^ x);
    endfunction

    // Call at a negedge; returns at the negedge of cycle 1 with inputs scrambled.
    task automatic start_seq(input logic [31:0] mux, input logic [5:0] x);
        wr_addr_q.delete();
        wr_data_q.delete();
        done_q.delete();
        watch_hit = 1'b0;
        start_i   = 1'b1;
        mux_val_i = mux;
        cfg_val_i = build_cfg(x);
        t0        = cyc;
        @(negedge HCLK);
        start_i   = 1'b0;
        mux_val_i = ~mux;
        cfg_val_i = ~build_cfg(x);
    endtask

    task automatic wait_cycle(input int c);
        for (int n = 0; n < 200 && (cyc - t0) < c; n++) @(negedge HCLK);
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int d;
        for (int n = 0; n < 300 && !done_o; n++) @(negedge HCLK);
        d = done_o ? (cyc - t0) : -1;
        check_eq({tag, "_done_cycle"}, 32'(d), 32'(exp_cyc));
        @(negedge HCLK);
        check_eq({tag, "_done_pulse_busy"}, {30'b0, done_o, busy_o}, 32'h0);
    endtask

    task automatic check_log(input string tag, input logic [31:0] mux, input logic [5:0] x,
                             input int n);
        check_eq({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(n));
        for (int j = 0; j < n && j < wr_addr_q.size(); j++) begin
            check_eq($sformatf("%s_addr%0d", tag, j), wr_addr_q[j], exp_addr(j));
            check_eq($sformatf("%s_data%0d", tag, j), wr_data_q[j], exp_data(j, mux, x));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        HRESET    = 1'b1;
        start_i   = 1'b0;
        mux_val_i = '0;
        cfg_val_i = '0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        PRDATA    = '0;
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        check_eq("rst_ctrl", {26'b0, busy_o, done_o, error_o, PSEL, PENABLE, PWRITE}, 32'h0);
        check_eq("rst_paddr", 32'(PADDR), 32'h0);
        check_eq("rst_pwdata", PWDATA, 32'h0);
        @(negedge HCLK);

        // Plain run: mux 0xDEADBEEF, pad k config = k.
        start_seq(32'hDEAD_BEEF, 6'h00);
        check_eq("t1_setup0", {29'b0, PSEL, PENABLE, PWRITE}, 32'h5);
        wait_done("t1", DONE_CYC);
        check_eq("t1_error", 32'(error_o), 32'h0);
        check_log("t1", 32'hDEAD_BEEF, 6'h00, NP + 1);
        if (wr_data_q.size() > NP) begin
            check_eq("t1_pad3_data", wr_data_q[4], 32'h0000_0021);
            check_eq("t1_last_addr", wr_addr_q[NP], 32'h0000_0284);
        end

        // Three wait states on entry 5 (pad 4, address 0x084).
        stall_addr = 32'h084;
        stall_left = 3;
        start_seq(32'h0F0F_1234, 6'h15);
        wait_cycle(EPC * 5 + 2);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t2_hold_ctl%0d", i), {30'b0, PSEL, PENABLE}, 32'h3);
            check_eq($sformatf("t2_hold_addr%0d", i), 32'(PADDR), 32'h084);
            check_eq($sformatf("t2_hold_data%0d", i), PWDATA, exp_data(5, 32'h0F0F_1234, 6'h15));
            @(negedge HCLK);
        end
        check_eq("t2_after_stall", {30'b0, PSEL, PENABLE}, 32'h2);
        wait_done("t2", DONE_CYC + 3);
        check_log("t2", 32'h0F0F_1234, 6'h15, NP + 1);
        stall_addr = -1;

        // Slave error on entry 2: abort, error sticky until the next start.
        err_addr   = 32'h024;
        watch_addr = 32'h044;
        start_seq(32'h1357_9BDF, 6'h2A);
        wait_done("t3", EPC * 2 + 3);
        check_eq("t3_error", 32'(error_o), 32'h1);
        check_eq("t3_nwrites", 32'(wr_addr_q.size()), 32'h2);
        check_eq("t3_no_entry3", 32'(watch_hit), 32'h0);
        err_addr   = -1;
        watch_addr = -1;
        start_seq(32'h1111_1111, 6'h01);
        check_eq("t3_error_cleared", 32'(error_o), 32'h0);
        wait_done("t3b", DONE_CYC);
        check_eq("t3b_error", 32'(error_o), 32'h0);

        // start_i mid-sequence is ignored.
        start_seq(32'hCAFE_F00D, 6'h02);
        wait_cycle(10);
        start_i   = 1'b1;
        mux_val_i = 32'h1234_5678;
        cfg_val_i = '1;
        @(negedge HCLK);
        start_i = 1'b0;
        wait_done("t4", DONE_CYC);
        check_log("t4", 32'hCAFE_F00D, 6'h02, NP + 1);
        repeat (4) @(negedge HCLK);
        check_eq("t4_one_done", 32'(done_q.size()), 32'h1);
        check_eq("t4_idle", 32'(busy_o), 32'h0);

        // Reset during ACCESS of entry 4 (pad 3, address 0x064).
        start_seq(32'h55AA_55AA, 6'h03);
        wait_cycle(EPC * 4 + 2);
        check_eq("t5_in_access", {30'b0, PSEL, PENABLE}, 32'h3);
        check_eq("t5_access_addr", 32'(PADDR), 32'h064);
        HRESET = 1'b1;
        @(negedge HCLK);
        check_eq("t5_after_rst", {29'b0, PSEL, PENABLE, busy_o}, 32'h0);
        HRESET = 1'b0;
        @(negedge HCLK);
        start_seq(32'hA5A5_A5A5, 6'h04);
        wait_done("t5", DONE_CYC);
        check_log("t5", 32'hA5A5_A5A5, 6'h04, NP + 1);

`ifdef PAD_CFG_VERIFY_EN
        // Corrupted read-back of pad 7 (address 0x0E4): stop before pad 8.
        bad_rd_addr = 32'h0E4;
        watch_addr  = 32'h104;
        start_seq(32'h0BAD_C0DE, 6'h07);
        wait_done("t6", 4 * 8 + 5);
        check_eq("t6_error", 32'(error_o), 32'h1);
        check_eq("t6_no_pad8", 32'(watch_hit), 32'h0);
        check_log("t6", 32'h0BAD_C0DE, 6'h07, 9);
        bad_rd_addr = -1;
        watch_addr  = -1;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
